// File: rtl/onehot_pkg.sv
// Shared types and defaults for the one-hot decoder: buffer occupancy states,
// stored entry layout and the even-parity helper.
package onehot_pkg;

  localparam int DEF_IN_W  = 3;
  localparam int DEF_CNT_W = 16;
  localparam int MAX_IN_W  = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // Code field is sized for the widest legal code; narrower builds zero-extend.
  typedef struct packed {
    logic                en;
    logic [MAX_IN_W-1:0] code;
  } entry_t;

  function automatic logic even_par(input logic en, input logic [MAX_IN_W-1:0] code);
    return en ^ (^code);
  endfunction

endpackage

// File: rtl/onehot_dec_core.sv
// Combinational decode of a stored {en, code} entry into a one-hot word.
module onehot_dec_core
  import onehot_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = 1 << IN_W
) (
  input  logic             en,
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] out,
  output logic             out_v
);

  always_comb begin
    out   = '0;
    out_v = en;
    if (en) out[code] = 1'b1;
  end

endmodule

// File: rtl/onehot_decoder.sv
// Valid/ready one-hot decoder with a 2-entry buffer; decode happens at the buffer head.
// Optional input parity checking is compiled in with ONEHOT_DECODER_PARITY_EN.
module onehot_decoder
  import onehot_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = 1 << IN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             in_en,
`ifdef ONEHOT_DECODER_PARITY_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_v,
  output logic [CNT_W-1:0] dec_cnt
);

  buf_state_e       state, state_nxt;
  logic             wr_ptr, rd_ptr;
  entry_t           mem [2];
  entry_t           wr_entry, head;
  logic             push, pop, bad_par;
  logic [OUT_W-1:0] core_out;
  logic             core_v;

  assign push      = in_valid & in_ready;
  assign out_valid = (state != EMPTY);
  assign pop       = out_valid & out_ready;

`ifdef ONEHOT_DECODER_PARITY_EN
  assign bad_par = in_par != even_par(in_en, MAX_IN_W'(in_code));
`else
  assign bad_par = 1'b0;
`endif

  // A parity-failed entry is still stored so ordering is kept, but decodes to zero.
  always_comb begin
    wr_entry.en   = in_en & ~bad_par;
    wr_entry.code = MAX_IN_W'(in_code);
  end

  always_comb begin
    state_nxt = state;
    unique case ({push, pop})
      2'b10: state_nxt = (state == EMPTY) ? ONE : FULL;
      2'b01: state_nxt = (state == FULL) ? ONE : EMPTY;
      default: state_nxt = state;
    endcase
  end

  // in_ready is derived from the next state so it stays registered and never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  assign head = mem[rd_ptr];

  onehot_dec_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .en   (head.en),
    .code (head.code[IN_W-1:0]),
    .out  (core_out),
    .out_v(core_v)
  );

  assign out   = out_valid ? core_out : '0;
  assign out_v = out_valid & core_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
    end else if (pop && out_v && (dec_cnt != '1)) begin
      dec_cnt <= dec_cnt + CNT_W'(1);
    end
  end

`ifdef ONEHOT_DECODER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= push & bad_par;
  end
`endif

endmodule
